r_format_cpu_pipe: RTL and testbench
====================================

// Module: r_format_cpu_pipe
// PURPOSE
//  Next-generation R-format CPU: a parametrised 3-stage pipeline (IF, EX, WB) with forwarding.
//  Keeps its own PC; the bench only releases reset, then waits for halted.
//  Instruction memory is byte-addressed and big-endian, one 32-bit word per 4 bytes.
//  The register file is preloaded by the bench through hierarchy.
//  The hierarchical names Instr_Memory.InstrMem[] and Register_File.R[] are mandatory.
// PARAMETERS
//  XLEN        32   datapath / register width (>=8)
//  REG_COUNT   32   architectural registers; index width = $clog2(REG_COUNT), R[0] reads 0
//  IMEM_BYTES  128  instruction memory size in bytes, multiple of 4
//  CNT_W       16   retire counter width
// PORTS
//  clk         in   1      rising-edge clock
//  rst         in   1      asynchronous, active-high reset
//  run         in   1      1 = advance pipeline; 0 = freeze all stages (no fetch, no write)
//  pc_out      out  32     address of the next instruction to fetch
//  halted      out  1      fetch exhausted and pipeline drained
//  retire_cnt  out  CNT_W  count of instructions leaving WB (NOPs included)
//  wb_valid    out  1      a register write happened this cycle
//  wb_idx      out  $clog2(REG_COUNT)  written register index
//  wb_data     out  XLEN   written data
// BEHAVIOUR
//  Reset (async): pc=0, IF/EX and EX/WB valid=0, halted=0, retire_cnt=0, wb_valid=0,
//    wb_idx=0, wb_data=0. InstrMem and R are NOT reset.
//  A reset mid-program discards in-flight instructions. Any write in progress is dropped.
//  IF: when run & pc<IMEM_BYTES, latch {Mem[pc],Mem[pc+1],Mem[pc+2],Mem[pc+3]}, then pc+=4.
//    When pc==IMEM_BYTES, stop fetching and insert a bubble (valid=0); pc holds.
//  EX: read rs=[25:21] and rt=[20:16]; rd=[15:11]; shamt=[10:6].
//    Register index is taken modulo REG_COUNT.
//    Forwarding: if the WB stage is writing rd!=0 with rd==rs (or rt), use the WB data.
//    Otherwise use the register-file value.
//    opcode!=0 or an unsupported funct -> NOP: travels to WB, no write.
//  Funct: 0x20 add, 0x22 sub, 0x24 and, 0x25 or, 0x27 nor, 0x2A slt (signed), 0x00 sll rt<<shamt,
//    0x02 srl rt>>shamt (logical). add/sub wrap modulo 2^XLEN; no overflow trap.
//    Shift amounts >= XLEN give 0.
//  WB: on a valid, writing instruction with rd!=0, write R[rd] at the clock edge.
//    wb_valid/wb_idx/wb_data are registered and reflect that write in the same cycle it is visible.
//    rd==0 gives no write and wb_valid=0; R[0] is always read as 0.
//  Latency: fetched at edge n, in EX during cycle n..n+1, written at edge n+2.
//    Throughput is 1 instruction per cycle; back-to-back dependents need no stalls.
//  retire_cnt increments for each valid EX/WB entry and wraps at 2^CNT_W.
//  halted=1 the cycle after the fetch has stopped and both valid bits are 0.
//    It is sticky until reset.
//  run=0: all stage registers, pc and the counter hold. Freezing during a pending write is lossless.
//  Simultaneous WB write and EX read of the same register: the forwarded value wins.
// STRUCTURE
//  Shared package rcpu_pkg: funct localparams, OPC_RTYPE=6'd0, field bit positions.
//  One sub-module, rcpu_alu (combinational: funct, a, b, shamt -> result, writes).
//  Instr_Memory and Register_File are instances inside this block so the bench can preload them.
// TESTING
//  1 Reset, then R1=5, R2=3; "add $3,$1,$2" at 0 -> R3=8 after 3 edges; retire_cnt=1.
//  2 Dependent chain: add $3,$1,$2; sub $4,$3,$1; or $5,$4,$3 -> R4=3, R5=0xB, no stalls.
//    Program is 3 instructions + NOPs.
//  3 Destination $0: "add $0,$1,$2" -> R0 stays 0, wb_valid=0.
//    A following "add $6,$0,$1" gives R6=5.
//  4 R1=0xFFFFFFFF, R2=1: add $7 gives 0; slt $8,$1,$2 gives 1; srl $9,$1,sh=28 gives 0xF;
//    nor $10,$0,$0 gives 0xFFFFFFFF.
//  5 Full 128-byte image (32 instrs) -> halted rises at cycle 34, retire_cnt=32, pc_out=128.
//    Check the RF dump against the golden file.
//  6 Drop run for 5 cycles and pulse rst mid-program -> no extra writes during the freeze.
//    After the reset: pc_out=0, retire_cnt=0, execution restarts cleanly.

Source files
------------

// File: rtl/rcpu_pkg.sv
// Shared decode constants for the R-format pipeline: opcode, funct codes, field positions.
package rcpu_pkg;
  localparam logic [5:0] OPC_RTYPE = 6'd0;

  localparam logic [5:0] F_SLL = 6'h00;
  localparam logic [5:0] F_SRL = 6'h02;
  localparam logic [5:0] F_ADD = 6'h20;
  localparam logic [5:0] F_SUB = 6'h22;
  localparam logic [5:0] F_AND = 6'h24;
  localparam logic [5:0] F_OR  = 6'h25;
  localparam logic [5:0] F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2A;

  localparam int OP_LSB = 26;
  localparam int RS_LSB = 21;
  localparam int RT_LSB = 16;
  localparam int RD_LSB = 11;
  localparam int SH_LSB = 6;
  localparam int FN_LSB = 0;
endpackage

// File: rtl/rcpu_alu.sv
// Combinational R-format ALU; writes=0 flags an unsupported funct (executes as a NOP).
module rcpu_alu
  import rcpu_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic [5:0]      funct,
  input  logic [XLEN-1:0] a,
  input  logic [XLEN-1:0] b,
  input  logic [4:0]      shamt,
  output logic [XLEN-1:0] result,
  output logic            writes
);
  logic sh_big;
  assign sh_big = (32'(shamt) >= XLEN);

  // funct decode and result select
  always_comb begin
    result = '0;
    writes = 1'b1;
    case (funct)
      F_ADD:   result = a + b;
      F_SUB:   result = a - b;
      F_AND:   result = a & b;
      F_OR:    result = a | b;
      F_NOR:   result = ~(a | b);
      F_SLT:   result[0] = ($signed(a) < $signed(b));
      F_SLL:   result = sh_big ? '0 : (b << shamt);
      F_SRL:   result = sh_big ? '0 : (b >> shamt);
      default: writes = 1'b0;
    endcase
  end
endmodule

// File: rtl/rcpu_imem.sv
// Byte-wide big-endian instruction store; normally preloaded from outside, load port kept for completeness.
module rcpu_imem #(
  parameter int IMEM_BYTES = 128
) (
  input  logic                          clk,
  input  logic                          load_en,
  input  logic [$clog2(IMEM_BYTES)-1:0] load_addr,
  input  logic [7:0]                    load_byte,
  input  logic [$clog2(IMEM_BYTES)-1:0] addr,
  output logic [31:0]                   word
);
  localparam int AW = $clog2(IMEM_BYTES);

  logic [7:0] InstrMem [IMEM_BYTES];

  // optional byte load
  always_ff @(posedge clk) begin
    if (load_en) InstrMem[load_addr] <= load_byte;
  end

  assign word = {InstrMem[addr],
                 InstrMem[addr | AW'(1)],
                 InstrMem[addr | AW'(2)],
                 InstrMem[addr | AW'(3)]};
endmodule

// File: rtl/rcpu_rf.sv
// Register file: two async read ports, one write port; R[0] reads as zero and is never written.
module rcpu_rf #(
  parameter int XLEN      = 32,
  parameter int REG_COUNT = 32
) (
  input  logic                         clk,
  input  logic                         we,
  input  logic [$clog2(REG_COUNT)-1:0] wa,
  input  logic [XLEN-1:0]              wd,
  input  logic [$clog2(REG_COUNT)-1:0] ra1,
  input  logic [$clog2(REG_COUNT)-1:0] ra2,
  output logic [XLEN-1:0]              rd1,
  output logic [XLEN-1:0]              rd2
);
  logic [XLEN-1:0] R [REG_COUNT];

  // write port, contents are not reset
  always_ff @(posedge clk) begin
    if (we && wa != '0) R[wa] <= wd;
  end

  assign rd1 = (ra1 == '0) ? '0 : R[ra1];
  assign rd2 = (ra2 == '0) ? '0 : R[ra2];
endmodule

// File: rtl/r_format_cpu_pipe.sv
// Three-stage R-format pipeline (IF, EX, WB) with WB->EX forwarding, run/freeze and halt detect.
module r_format_cpu_pipe
  import rcpu_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int REG_COUNT  = 32,
  parameter int IMEM_BYTES = 128,
  parameter int CNT_W      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         run,
  output logic [31:0]                  pc_out,
  output logic                         halted,
  output logic [CNT_W-1:0]             retire_cnt,
  output logic                         wb_valid,
  output logic [$clog2(REG_COUNT)-1:0] wb_idx,
  output logic [XLEN-1:0]              wb_data
);
  localparam int IDX_W = $clog2(REG_COUNT);
  localparam int AW    = $clog2(IMEM_BYTES);

  // 5-bit instruction fields fold onto the implemented register count
  function automatic logic [IDX_W-1:0] ridx(input logic [4:0] f);
    return IDX_W'(32'(f) % REG_COUNT);
  endfunction

  logic [31:0]      pc, imem_word, ifex_ir;
  logic             ifex_v, exwb_v, exwb_we;
  logic [IDX_W-1:0] exwb_rd, rs_idx, rt_idx, rd_idx;
  logic [XLEN-1:0]  exwb_data, rf_a, rf_b, op_a, op_b, alu_res;
  logic             alu_writes, ex_we, wr, fetch_more;

  assign pc_out     = pc;
  assign fetch_more = (pc < 32'(IMEM_BYTES));

  rcpu_imem #(.IMEM_BYTES(IMEM_BYTES)) Instr_Memory (
    .clk(clk), .load_en(1'b0), .load_addr('0), .load_byte('0),
    .addr(pc[AW-1:0]), .word(imem_word)
  );

  // EX decode
  assign rs_idx = ridx(ifex_ir[RS_LSB +: 5]);
  assign rt_idx = ridx(ifex_ir[RT_LSB +: 5]);
  assign rd_idx = ridx(ifex_ir[RD_LSB +: 5]);

  // exwb_we already excludes rd==0, so a hit never forwards into $0
  assign op_a = (exwb_v && exwb_we && exwb_rd == rs_idx) ? exwb_data : rf_a;
  assign op_b = (exwb_v && exwb_we && exwb_rd == rt_idx) ? exwb_data : rf_b;

  rcpu_alu #(.XLEN(XLEN)) u_alu (
    .funct(ifex_ir[FN_LSB +: 6]), .a(op_a), .b(op_b),
    .shamt(ifex_ir[SH_LSB +: 5]), .result(alu_res), .writes(alu_writes)
  );

  assign ex_we = alu_writes && (ifex_ir[OP_LSB +: 6] == OPC_RTYPE) && (rd_idx != '0);

  // the WB write only fires while running, so a freeze keeps it pending
  assign wr = run && exwb_v && exwb_we;

  rcpu_rf #(.XLEN(XLEN), .REG_COUNT(REG_COUNT)) Register_File (
    .clk(clk), .we(wr), .wa(exwb_rd), .wd(exwb_data),
    .ra1(rs_idx), .ra2(rt_idx), .rd1(rf_a), .rd2(rf_b)
  );

  // pipeline registers, pc, retire counter, WB report and sticky halt
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc         <= '0;
      ifex_v     <= 1'b0;
      ifex_ir    <= '0;
      exwb_v     <= 1'b0;
      exwb_we    <= 1'b0;
      exwb_rd    <= '0;
      exwb_data  <= '0;
      retire_cnt <= '0;
      wb_valid   <= 1'b0;
      wb_idx     <= '0;
      wb_data    <= '0;
      halted     <= 1'b0;
    end else begin
      if (run) begin
        if (fetch_more) begin
          ifex_v  <= 1'b1;
          ifex_ir <= imem_word;
          pc      <= pc + 32'd4;
        end else begin
          ifex_v  <= 1'b0;
        end
        exwb_v    <= ifex_v;
        exwb_we   <= ifex_v && ex_we;
        exwb_rd   <= rd_idx;
        exwb_data <= alu_res;
        if (exwb_v) retire_cnt <= retire_cnt + CNT_W'(1);
        wb_valid <= wr;
        if (wr) begin
          wb_idx  <= exwb_rd;
          wb_data <= exwb_data;
        end
      end else begin
        wb_valid <= 1'b0;
      end
      if (pc == 32'(IMEM_BYTES) && !ifex_v && !exwb_v) halted <= 1'b1;
    end
  end
endmodule

// File: tb/tb_r_format_cpu_pipe.sv
// Scoreboard bench: a sequential ISA model predicts every register write; writes are checked as they retire.
module tb_r_format_cpu_pipe;
  logic        clk, rst, run;
  logic [31:0] pc_out;
  logic        halted;
  logic [15:0] retire_cnt;
  logic        wb_valid;
  logic [4:0]  wb_idx;
  logic [31:0] wb_data;

  r_format_cpu_pipe dut (
    .clk(clk), .rst(rst), .run(run), .pc_out(pc_out), .halted(halted),
    .retire_cnt(retire_cnt), .wb_valid(wb_valid), .wb_idx(wb_idx), .wb_data(wb_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {logic [4:0] idx; logic [31:0] data;} wr_t;
  wr_t         exp_q [$];
  wr_t         got_e;
  logic [31:0] prog [32];
  logic [31:0] init [32];
  logic [31:0] mreg [32];
  int          checks = 0, errors = 0;
  int          cyc = 0, rel = 0, frz_wr = 0;
  bit          freezing = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] enc(input logic [5:0] f, input int rd, input int rs,
                                      input int rt, input int sh);
    return {6'd0, 5'(rs), 5'(rt), 5'(rd), 5'(sh), f};
  endfunction

  // retiring writes are compared in order against the model's predictions
  always @(negedge clk) begin
    if (!rst && wb_valid) begin
      if (freezing) frz_wr++;
      if (exp_q.size() == 0) chk("wb_unexpected", 1, 0);
      else begin
        got_e = exp_q.pop_front();
        chk("wb_idx", wb_idx, got_e.idx);
        chk("wb_data", wb_data, got_e.data);
      end
    end
  end

  // sequential reference execution of prog[] on init[]
  task automatic build_exp();
    logic [31:0] w, a, b, res;
    logic        wr;
    int          rd;
    wr_t         e;
    exp_q.delete();
    for (int i = 0; i < 32; i++) mreg[i] = (i == 0) ? 32'd0 : init[i];
    for (int i = 0; i < 32; i++) begin
      w  = prog[i];
      a  = mreg[w[25:21]];
      b  = mreg[w[20:16]];
      rd = int'(w[15:11]);
      wr = 1'b1;
      res = 32'd0;
      case (w[5:0])
        6'h20: res = a + b;
        6'h22: res = a - b;
        6'h24: res = a & b;
        6'h25: res = a | b;
        6'h27: res = ~(a | b);
        6'h2A: res = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
        6'h00: res = b << w[10:6];
        6'h02: res = b >> w[10:6];
        default: wr = 1'b0;
      endcase
      if (w[31:26] != 6'd0) wr = 1'b0;
      if (wr && rd != 0) begin
        mreg[rd] = res;
        e.idx = 5'(rd);
        e.data = res;
        exp_q.push_back(e);
      end
    end
  endtask

  task automatic prog_start();
    #1 rst = 1'b1;
    run = 1'b1;
    for (int i = 0; i < 32; i++) begin
      dut.Register_File.R[i] = (i == 0) ? 32'd0 : init[i];
      for (int k = 0; k < 4; k++)
        dut.Instr_Memory.InstrMem[4*i+k] = prog[i][31-8*k -: 8];
    end
    build_exp();
    @(negedge clk);
    #1 rst = 1'b0;
    rel = cyc;
  endtask

  task automatic prog_wait(input int exp_edge);
    bit got = 1'b0;
    for (int k = 0; k < 300 && !got; k++) begin
      @(negedge clk);
      if (halted) got = 1'b1;
    end
    chk("halt_seen", got, 1);
    if (got) chk("halt_edge", cyc - rel - 1, exp_edge);
    chk("retire_cnt", retire_cnt, 32);
    chk("pc_out", pc_out, 128);
    chk("queue_left", exp_q.size(), 0);
    for (int i = 0; i < 32; i++)
      chk($sformatf("rf%0d", i), dut.Register_File.R[i], mreg[i]);
  endtask

  task automatic clear_prog();
    for (int i = 0; i < 32; i++) begin
      prog[i] = 32'd0;
      init[i] = (i == 0) ? 32'd0 : 32'h100 + i;
    end
  endtask

  logic [5:0] fl [9] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h27, 6'h2A, 6'h00, 6'h02, 6'h21};

  task automatic rand_prog();
    logic [31:0] w;
    for (int i = 0; i < 32; i++) begin
      init[i] = (i == 0) ? 32'd0 : $urandom;
      w = enc(fl[$urandom_range(0, 8)], $urandom_range(0, 9), $urandom_range(0, 9),
              $urandom_range(0, 9), $urandom_range(0, 31));
      if (i % 8 == 5) w[31:26] = 6'h23;
      prog[i] = w;
    end
  endtask

  initial begin
    logic [31:0] pc_hold;
    logic [15:0] rc_hold;
    rst = 1'b1;
    run = 1'b1;
    repeat (3) @(negedge clk);
    chk("rst_pc", pc_out, 0);
    chk("rst_halted", halted, 0);
    chk("rst_retire", retire_cnt, 0);
    chk("rst_wb_valid", wb_valid, 0);
    chk("rst_wb_idx", wb_idx, 0);
    chk("rst_wb_data", wb_data, 0);

    // single add, written on the third edge
    clear_prog();
    init[1] = 32'd5; init[2] = 32'd3;
    prog[0] = enc(6'h20, 3, 1, 2, 0);
    prog_start();
    repeat (3) @(negedge clk);
    chk("t1_r3", dut.Register_File.R[3], 8);
    chk("t1_retire", retire_cnt, 1);
    chk("t1_wb_valid", wb_valid, 1);
    prog_wait(34);

    // back-to-back dependent chain through forwarding
    clear_prog();
    init[1] = 32'd5; init[2] = 32'd3;
    prog[0] = enc(6'h20, 3, 1, 2, 0);
    prog[1] = enc(6'h22, 4, 3, 1, 0);
    prog[2] = enc(6'h25, 5, 4, 3, 0);
    prog_start();
    prog_wait(34);
    chk("t2_r4", dut.Register_File.R[4], 3);
    chk("t2_r5", dut.Register_File.R[5], 32'hB);

    // destination $0 is discarded, $0 reads zero
    clear_prog();
    init[1] = 32'd5; init[2] = 32'd3;
    prog[0] = enc(6'h20, 0, 1, 2, 0);
    prog[1] = enc(6'h20, 6, 0, 1, 0);
    prog_start();
    repeat (3) @(negedge clk);
    chk("t3_no_wb", wb_valid, 0);
    @(negedge clk);
    chk("t3_wb6", wb_valid, 1);
    chk("t3_wb6_idx", wb_idx, 6);
    prog_wait(34);
    chk("t3_r0", dut.Register_File.R[0], 0);
    chk("t3_r6", dut.Register_File.R[6], 5);

    // wrap, signed compare, logical shift, nor
    clear_prog();
    init[1] = 32'hFFFF_FFFF; init[2] = 32'd1;
    prog[0] = enc(6'h20, 7, 1, 2, 0);
    prog[1] = enc(6'h2A, 8, 1, 2, 0);
    prog[2] = enc(6'h02, 9, 0, 1, 28);
    prog[3] = enc(6'h27, 10, 0, 0, 0);
    prog_start();
    prog_wait(34);
    chk("t4_add_wrap", dut.Register_File.R[7], 0);
    chk("t4_slt", dut.Register_File.R[8], 1);
    chk("t4_srl", dut.Register_File.R[9], 32'hF);
    chk("t4_nor", dut.Register_File.R[10], 32'hFFFF_FFFF);

    // full random image
    rand_prog();
    prog_start();
    prog_wait(34);
    repeat (3) @(negedge clk);
    chk("t5_halt_sticky", halted, 1);

    // freeze mid-program: nothing moves, nothing lost
    rand_prog();
    prog_start();
    repeat (10) @(negedge clk);
    pc_hold = pc_out;
    rc_hold = retire_cnt;
    #1 run = 1'b0;
    freezing = 1'b1;
    frz_wr = 0;
    repeat (5) @(negedge clk);
    chk("t6_frz_pc", pc_out, pc_hold);
    chk("t6_frz_retire", retire_cnt, rc_hold);
    chk("t6_frz_writes", frz_wr, 0);
    #1 run = 1'b1;
    freezing = 1'b0;
    prog_wait(39);

    // reset mid-program, then a clean restart
    rand_prog();
    prog_start();
    repeat (12) @(negedge clk);
    #1 rst = 1'b1;
    @(negedge clk);
    chk("t6_rst_pc", pc_out, 0);
    chk("t6_rst_retire", retire_cnt, 0);
    chk("t6_rst_wb_valid", wb_valid, 0);
    chk("t6_rst_halted", halted, 0);
    rand_prog();
    prog_start();
    prog_wait(34);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
